// File: rtl/pipe_ctrl_pkg.sv
// Shared types and defaults for the pipeline control unit.
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    MC_WAIT = 2'd1,
    FLUSH   = 2'd2
  } state_t;

  // Default stall-bus width: PC register plus five pipeline registers.
  localparam int unsigned STAGES_DEF = 6;

endpackage

// File: rtl/pipe_ctrl_pc_sat_counter.sv
// Saturating up-counter with enable; holds at all-ones once reached.
module pc_sat_counter #(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  output logic [CNT_W-1:0] count
);

  always_ff @(posedge clk) begin
    if (!rst) begin
      count <= '0;
    end else if (en && (count != '1)) begin
      count <= count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline control: per-stage stall/bubble encode, multi-cycle hold,
// exception flush with redirect PC, and a stall-cycle counter.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned STAGES    = STAGES_DEF,
  parameter int unsigned MC_STAGE  = 3,
  parameter int unsigned FLUSH_LEN = 1,
  parameter int unsigned CNT_W     = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [STAGES-1:0] stallreq,
  input  logic              mc_start,
  input  logic              mc_done,
  input  logic              excp_valid,
  input  logic [31:0]       excp_pc,
  output logic [STAGES-1:0] stall,
  output logic [STAGES-1:0] bubble,
  output logic              flush,
  output logic [31:0]       flush_pc,
  output logic              mc_cancel,
  output logic [CNT_W-1:0]  stall_cycles
);

  localparam int unsigned FL_W = (FLUSH_LEN > 1) ? $clog2(FLUSH_LEN) : 1;

  state_t          state;
  logic [FL_W-1:0] flush_left;
  logic            mc_hold;
  logic            active;
  int unsigned     level;

  // A zero-latency op (start and done together) never holds MC_STAGE.
  assign mc_hold = ((state == MC_WAIT) && !mc_done) ||
                   ((state == RUN) && mc_start && !mc_done);

  always_comb begin
    active = 1'b0;
    level  = 0;
    stall  = '0;
    bubble = '0;
    for (int unsigned i = 0; i < STAGES; i++) begin
      if (stallreq[i]) begin
        active = 1'b1;
        level  = i;
      end
    end
    if (mc_hold && (!active || (MC_STAGE > level))) begin
      active = 1'b1;
      level  = MC_STAGE;
    end
    if (rst && (state != FLUSH) && !excp_valid && active) begin
      for (int unsigned i = 0; i < STAGES; i++) begin
        stall[i]  = (i <= level);
        bubble[i] = (i == level + 1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= RUN;
      flush      <= 1'b0;
      flush_pc   <= '0;
      mc_cancel  <= 1'b0;
      flush_left <= '0;
    end else begin
      mc_cancel <= 1'b0;
      unique case (state)
        RUN: begin
          if (excp_valid) begin
            state      <= FLUSH;
            flush      <= 1'b1;
            flush_pc   <= excp_pc;
            flush_left <= FL_W'(FLUSH_LEN - 1);
          end else if (mc_start && !mc_done) begin
            state <= MC_WAIT;
          end
        end
        MC_WAIT: begin
          if (excp_valid) begin
            state      <= FLUSH;
            flush      <= 1'b1;
            flush_pc   <= excp_pc;
            flush_left <= FL_W'(FLUSH_LEN - 1);
            mc_cancel  <= 1'b1;
          end else if (mc_done) begin
            state <= RUN;
          end
        end
        FLUSH: begin
          if (flush_left == '0) begin
            state <= RUN;
            flush <= 1'b0;
          end else begin
            flush_left <= flush_left - FL_W'(1);
          end
        end
        default: state <= RUN;
      endcase
    end
  end

  pc_sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst   (rst),
    .en    (stall[0]),
    .count (stall_cycles)
  );

endmodule

// File: tb/tb_pipe_ctrl.sv
// Scoreboard bench for pipe_ctrl: driver pushes model expectations, monitor compares.
module tb_pipe_ctrl;

  localparam int NST  = 6;
  localparam int MCS  = 3;
  localparam int FLEN = 3;
  localparam int CW   = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic [NST-1:0]   stallreq;
  logic             mc_start, mc_done, excp_valid;
  logic [31:0]      excp_pc;
  logic [NST-1:0]   stall, bubble;
  logic             flush, mc_cancel;
  logic [31:0]      flush_pc;
  logic [CW-1:0]    stall_cycles;

  pipe_ctrl #(.STAGES(NST), .MC_STAGE(MCS), .FLUSH_LEN(FLEN), .CNT_W(CW)) dut (
    .clk          (clk),
    .rst          (rst),
    .stallreq     (stallreq),
    .mc_start     (mc_start),
    .mc_done      (mc_done),
    .excp_valid   (excp_valid),
    .excp_pc      (excp_pc),
    .stall        (stall),
    .bubble       (bubble),
    .flush        (flush),
    .flush_pc     (flush_pc),
    .mc_cancel    (mc_cancel),
    .stall_cycles (stall_cycles)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [NST-1:0] stall;
    logic [NST-1:0] bubble;
    logic           flush;
    logic [31:0]    pc;
    logic           cancel;
    logic [CW-1:0]  cnt;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  // Reference model: high-level view of the controller.
  bit          m_in_mc;
  int          m_flush_left;
  logic [31:0] m_pc;
  bit          m_cancel;
  int          m_cnt;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %h, expected %h at %0t", name, act, req, $time);
  endtask

  task automatic cyc(input logic r, input logic [NST-1:0] req, input logic st,
                     input logic dn, input logic ex, input logic [31:0] pc);
    exp_t e;
    int   lvl;
    @(negedge clk);
    rst = r; stallreq = req; mc_start = st; mc_done = dn; excp_valid = ex; excp_pc = pc;
    lvl = -1;
    for (int i = 0; i < NST; i++) if (req[i]) lvl = i;
    if (m_in_mc ? !dn : (st && !dn)) lvl = (lvl > MCS) ? lvl : MCS;
    if (!r || m_flush_left > 0 || ex) lvl = -1;
    e.stall  = (lvl < 0) ? '0 : NST'((1 << (lvl + 1)) - 1);
    e.bubble = (lvl >= 0 && lvl + 1 < NST) ? NST'(1 << (lvl + 1)) : '0;
    e.flush  = (m_flush_left > 0);
    e.pc     = m_pc;
    e.cancel = m_cancel;
    e.cnt    = CW'(m_cnt);
    q.push_back(e);
    if (!r) begin
      m_in_mc = 0; m_flush_left = 0; m_pc = '0; m_cancel = 0; m_cnt = 0;
    end else begin
      m_cancel = 0;
      if (e.stall[0] && m_cnt < (1 << CW) - 1) m_cnt++;
      if (m_flush_left > 0) m_flush_left--;
      else if (ex) begin
        m_cancel = m_in_mc; m_in_mc = 0; m_flush_left = FLEN; m_pc = pc;
      end else if (m_in_mc) begin
        if (dn) m_in_mc = 0;
      end else if (st && !dn) m_in_mc = 1;
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (q.size() > 0) begin
        e = q.pop_front();
        check("stall",        32'(stall),        32'(e.stall));
        check("bubble",       32'(bubble),       32'(e.bubble));
        check("flush",        32'(flush),        32'(e.flush));
        check("flush_pc",     flush_pc,          e.pc);
        check("mc_cancel",    32'(mc_cancel),    32'(e.cancel));
        check("stall_cycles", 32'(stall_cycles), 32'(e.cnt));
      end
    end
  end

  initial begin : driver
    rst = 0; stallreq = '0; mc_start = 0; mc_done = 0; excp_valid = 0; excp_pc = '0;
    m_in_mc = 0; m_flush_left = 0; m_pc = '0; m_cancel = 0; m_cnt = 0;
    @(posedge clk);
    // reset with all requests asserted
    repeat (3) cyc(0, 6'b111111, 0, 0, 0, 0);
    cyc(1, 6'b000000, 0, 0, 0, 0);
    // single stage request
    repeat (2) cyc(1, 6'b000100, 0, 0, 0, 0);
    cyc(1, 6'b000000, 0, 0, 0, 0);
    // multi-cycle op: start at 0, done at 4
    cyc(1, 0, 1, 0, 0, 0);
    repeat (3) cyc(1, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 1, 0, 0);
    cyc(1, 6'b000001, 0, 0, 0, 0);
    // exception during MC_WAIT, second exception inside FLUSH
    cyc(1, 0, 1, 0, 0, 0);
    cyc(1, 6'b000010, 0, 0, 0, 0);
    cyc(1, 6'b100000, 0, 0, 1, 32'hBFC00380);
    cyc(1, 6'b111111, 1, 0, 1, 32'h80000180);
    cyc(1, 6'b000001, 0, 1, 0, 0);
    cyc(1, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0);
    // zero-latency op with a low request
    cyc(1, 6'b000010, 1, 1, 0, 0);
    cyc(1, 6'b000000, 0, 0, 0, 0);
    // reset mid-MC_WAIT and mid-FLUSH
    cyc(1, 0, 1, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 1, 32'h12345678);
    cyc(0, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0);
    // counter saturation
    cyc(0, 0, 0, 0, 0, 0);
    repeat (20) cyc(1, 6'b000001, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0);
    // randomized traffic
    for (int n = 0; n < 600; n++) begin
      cyc(($urandom_range(0, 49) != 0),
          ($urandom_range(0, 1) != 0) ? NST'(0) : NST'($urandom),
          ($urandom_range(0, 5) == 0),
          ($urandom_range(0, 3) == 0),
          ($urandom_range(0, 19) == 0),
          $urandom);
    end
    @(negedge clk);
    #4;
    n_checks++;
    if (q.size() == 0) n_pass++;
    else $display("FAIL scoreboard_drain: %0d left, expected 0", q.size());
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
